// File: rtl/adc_stream_source.sv
// adc_stream_source: captures a programmed number of ADC samples after an arm
// request and buffers them in a first-word-fall-through FIFO. The FIFO drives
// an ap_fifo-style read side (dout / empty_n / read).
// Build option: define ADC_OFFSET_BINARY_EN to convert offset-binary samples to
// two's complement on write (MSB inversion); leave it undefined for front ends
// that already produce two's complement.
module adc_stream_source #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic [CNT_W-1:0]  num_samples,
  output logic [DATA_W-1:0] datain_V_dout,
  output logic              datain_V_empty_n,
  input  logic              datain_V_read,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [AW:0]       level
);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               overflow_q, overflow_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               full;
  logic               rd_en;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;

  // Sample format conversion applied before the word enters storage.
`ifdef ADC_OFFSET_BINARY_EN
  assign wr_data = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`else
  assign wr_data = adc_data;
`endif

  // FIFO handshake decode and pointer/occupancy next state.
  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    rd_en    = datain_V_read && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    wr_en    = (state_q == StCapture) && adc_valid && (!full || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Capture control FSM: next state, sample countdown and sticky overflow.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          remaining_d = num_samples;
          overflow_d  = 1'b0;
          state_d     = (num_samples == '0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (adc_valid) begin
          // Dropped samples still count toward the programmed total.
          remaining_d = remaining_q - CNT_W'(1);
          if (!wr_en) overflow_d = 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (level_q == '0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointer and occupancy registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Outputs decode registered state only; dout is forced to zero while empty
  // so it never exposes uninitialised storage.
  assign datain_V_empty_n = (level_q != '0);
  assign datain_V_dout    = datain_V_empty_n ? mem_q[rd_ptr_q] : '0;
  assign busy             = (state_q == StCapture) || (state_q == StDrain);
  assign done             = (state_q == StDone);
  assign overflow         = overflow_q;
  assign level            = level_q;

endmodule

// File: tb/tb_adc_stream_source.sv
// Scoreboard bench for adc_stream_source: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted read.
module tb_adc_stream_source;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [9:0]  adc_data;
  logic        adc_valid;
  logic        arm;
  logic [15:0] num_samples;
  logic [9:0]  datain_V_dout;
  logic        datain_V_empty_n;
  logic        datain_V_read;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  level;

  logic [9:0]  sb [$];
  logic [9:0]  mon_exp;
  int          vectors     = 0;
  int          miscompares = 0;
  int          pops        = 0;
  int          p0;

  adc_stream_source #(.DEPTH(16), .DATA_W(10), .CNT_W(16)) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .adc_data         (adc_data),
    .adc_valid        (adc_valid),
    .arm              (arm),
    .num_samples      (num_samples),
    .datain_V_dout    (datain_V_dout),
    .datain_V_empty_n (datain_V_empty_n),
    .datain_V_read    (datain_V_read),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .level            (level)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [9:0] conv(input logic [9:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
    return raw ^ 10'h200;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic sample(input logic [9:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
  endtask

  task automatic do_arm(input logic [15:0] n);
    num_samples = n;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) tick();
    chk("done_wait", {31'b0, done}, 32'd1);
  endtask

  // Monitor: every accepted pop must match the head of the scoreboard.
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && datain_V_read === 1'b1 && datain_V_empty_n === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {31'b0, datain_V_empty_n}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("dout", {22'b0, datain_V_dout}, {22'b0, mon_exp});
        pops++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; arm = 1'b0;
    num_samples = '0; datain_V_read = 1'b0;

    // Reset values
    repeat (4) tick();
    chk("rst_empty_n", {31'b0, datain_V_empty_n}, 32'd0);
    chk("rst_dout", {22'b0, datain_V_dout}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_level", {27'b0, level}, 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // Read while empty is ignored
    datain_V_read = 1'b1;
    tick();
    datain_V_read = 1'b0;
    chk("empty_read_level", {27'b0, level}, 32'd0);
    chk("empty_read_empty_n", {31'b0, datain_V_empty_n}, 32'd0);

    // num_samples = 0 goes straight to DONE
    do_arm(16'd0);
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    chk("zero_level", {27'b0, level}, 32'd0);

    // Basic stream with read held high
    datain_V_read = 1'b1;
`ifdef ADC_OFFSET_BINARY_EN
    sb.push_back(10'h200); sb.push_back(10'h000); sb.push_back(10'h1FF);
`else
    sb.push_back(10'h000); sb.push_back(10'h200); sb.push_back(10'h3FF);
`endif
    do_arm(16'd3);
    chk("basic_busy", {31'b0, busy}, 32'd1);
    sample(10'd0);
    sample(10'd512);
    sample(10'd1023);
    adc_valid = 1'b0;
    for (int i = 0; i < 20 && level != 5'd0; i++) tick();
    chk("basic_drain_hold", {31'b0, done}, 32'd0);
    tick();
    chk("basic_done", {31'b0, done}, 32'd1);
    chk("basic_overflow", {31'b0, overflow}, 32'd0);
    chk("basic_pops", pops, 32'd3);

    // Overflow: 20 samples into a 16-deep FIFO with no reads
    datain_V_read = 1'b0;
    do_arm(16'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) sb.push_back(conv(10'(i * 51)));
      sample(10'(i * 51));
    end
    adc_valid = 1'b0;
    chk("ovf_level", {27'b0, level}, 32'd16);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_busy", {31'b0, busy}, 32'd1);
    chk("ovf_not_done", {31'b0, done}, 32'd0);
    repeat (3) tick();
    chk("ovf_drain_hold", {31'b0, busy}, 32'd1);
    p0 = pops;
    datain_V_read = 1'b1;
    wait_done();
    chk("ovf_pop_count", pops - p0, 32'd16);
    chk("ovf_level_end", {27'b0, level}, 32'd0);

    // Full FIFO with simultaneous read and write
    datain_V_read = 1'b0;
    do_arm(16'd21);
    chk("full_ovf_cleared", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      sb.push_back(conv(10'(1023 - i * 7)));
      sample(10'(1023 - i * 7));
    end
    chk("full_level", {27'b0, level}, 32'd16);
    datain_V_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(conv(10'(i * 100 + 3)));
      sample(10'(i * 100 + 3));
      chk("full_rw_level", {27'b0, level}, 32'd16);
    end
    adc_valid = 1'b0;
    chk("full_rw_overflow", {31'b0, overflow}, 32'd0);
    wait_done();
    chk("full_rw_level_end", {27'b0, level}, 32'd0);

    // Reset mid-capture at level 7
    datain_V_read = 1'b0;
    do_arm(16'd10);
    for (int i = 0; i < 7; i++) begin
      sb.push_back(conv(10'(300 + i)));
      sample(10'(300 + i));
    end
    adc_valid = 1'b0;
    chk("mid_level", {27'b0, level}, 32'd7);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    ap_rst_n = 1'b0;
    tick();
    sb.delete();
    chk("mid_rst_level", {27'b0, level}, 32'd0);
    chk("mid_rst_empty_n", {31'b0, datain_V_empty_n}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // Single mid-scale sample: passthrough or converted depending on build
    do_arm(16'd1);
    sb.push_back(conv(10'd512));
    sample(10'd512);
    adc_valid = 1'b0;
`ifdef ADC_OFFSET_BINARY_EN
    chk("mid_scale_dout", {22'b0, datain_V_dout}, 32'h000);
`else
    chk("mid_scale_dout", {22'b0, datain_V_dout}, 32'h200);
`endif
    datain_V_read = 1'b1;
    wait_done();
    datain_V_read = 1'b0;
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_stream_source.md
# adc_stream_source

Producer end of the sample stream consumed by the moving-sum trigger engine. Captures raw 10-bit ADC samples after an `arm` request, converts them from offset-binary to two's complement, and buffers them in a first-word-fall-through FIFO. The FIFO presents the `ap_fifo` read-side handshake (`dout` / `empty_n` / `read`) expected by the HLS `datain_V` port. Sits between the ADC capture register and the trigger datapath.

## Interface
- `DEPTH`, 16: FIFO depth in words. Power of two, ≥ 4.
- `DATA_W`, 10: sample width in bits.
- `CNT_W`, 16: width of the sample-count register.

Ports:
- `ap_clk`  in  1  single clock; all logic is on the rising edge.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `adc_data`  in  DATA_W  raw offset-binary ADC sample.
- `adc_valid`  in  1  `adc_data` is valid this cycle.
- `arm`  in  1  one-cycle pulse that starts a capture. Ignored unless the FSM is in IDLE or DONE.
- `num_samples`  in  CNT_W  number of samples to capture; latched on `arm`. A value of 0 means no capture (FSM goes straight to DONE).
- `datain_V_dout`  out  DATA_W  head-of-FIFO sample, two's complement.
- `datain_V_empty_n`  out  1  FIFO not empty; `dout` is valid.
- `datain_V_read`  in  1  consumer pops the head word.
- `busy`  out  1  FSM is in CAPTURE or DRAIN.
- `done`  out  1  FSM is in DONE.
- `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full. Cleared by `arm`.
- `level`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE, on `arm`: latch `num_samples` into `remaining`, clear `overflow`, go to CAPTURE. If `num_samples` = 0, go to DONE instead.
  - CAPTURE: each `adc_valid` cycle decrements `remaining`, whether or not the sample was written. When `remaining` goes 1→0, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, then go to DONE.
  - DONE: on `arm`, re-arm exactly as from IDLE. The FIFO is not flushed by `arm`; leftover words stay ahead of new samples.
- Write path:
  - Write occurs when state = CAPTURE, `adc_valid` = 1, and (not full, or full with `datain_V_read` && `empty_n` in the same cycle).
  - Otherwise a valid sample in CAPTURE is dropped and `overflow` is set.
  - `adc_valid` outside CAPTURE is ignored.
- Read path:
  - A pop occurs on `datain_V_read` && `datain_V_empty_n`.
  - `datain_V_read` while empty is ignored, with no state change.
- Pointers: `log2(DEPTH)`-bit read and write pointers wrap naturally. `level` is updated as +1 on a write, −1 on a pop, and unchanged when both or neither occur.
- Arithmetic: `dout` = stored sample − 2^(DATA_W−1), which is equivalent to inverting the MSB (see Configuration). No saturation is needed.
  - Example: 0 → −512, 512 → 0, 1023 → +511.

## Timing
- Reset values: state = IDLE, `datain_V_empty_n` = 0, `datain_V_dout` = 0, `busy` = 0, `done` = 0, `overflow` = 0, `level` = 0; pointers cleared. FIFO storage is not reset.
- Reset asserted mid-capture aborts immediately: the FIFO empties and the FSM returns to IDLE on the next edge.
- Write latency: a sample written at edge N drives `empty_n` = 1 and a valid `dout` from edge N onward (registered outputs, visible in cycle N+1).
- Read timing:
  - A pop at edge N presents the next word, or deasserts `empty_n`, after edge N.
  - Back-to-back pops at one word per cycle are sustained.
- Simultaneous read and write at `level` = 1: `empty_n` stays 1 and `dout` advances to the new word.
- Simultaneous read and write at full: both succeed and `level` stays at DEPTH.
- `busy` and `done` are decoded from registered state.
- DONE is entered the cycle after the last pop in DRAIN.
- `arm` in CAPTURE or DRAIN is ignored.

## Configuration
- `ADC_OFFSET_BINARY_EN`
  - Defined: samples are converted from offset-binary to two's complement on write, by inverting the MSB.
  - Undefined: samples pass through unmodified. Use this for ADC front ends that already output two's complement.

## Test plan
- Reset and empty read:
  - Hold `ap_rst_n` = 0 for 4 cycles → all outputs at their reset values.
  - Pulse `datain_V_read` while empty → `level` stays 0 and `empty_n` stays 0.
- Basic stream (`ADC_OFFSET_BINARY_EN` defined):
  - `arm` with `num_samples` = 3; `adc_data` = 0, 512, 1023 with `adc_valid` continuous; `read` held high.
  - → `dout` sequence −512, 0, +511; `done` = 1 one cycle after the last pop; `overflow` = 0.
- Overflow:
  - `DEPTH` = 16, `num_samples` = 20, `read` held low.
  - → `level` saturates at 16, `overflow` = 1, FSM stays in DRAIN.
  - Then assert `read` → exactly 16 words popped (samples 0–15), then DONE.
- Full with simultaneous read/write:
  - At `level` = 16, assert `read` and `adc_valid` together for 5 cycles.
  - → `level` stays 16, no overflow, output order is preserved.
- Edge cases:
  - `num_samples` = 0 → DONE on the next edge, `level` = 0.
  - Reset asserted mid-CAPTURE at `level` = 7 → IDLE, `level` = 0, `empty_n` = 0 on the next edge.
- Passthrough (`ADC_OFFSET_BINARY_EN` undefined):
  - `adc_data` = 512 → `dout` = 10'h200.
